nibble_pack8: RTL and testbench

- Inverse of the 8-way nibble selector: assembles a serial stream of 4-bit nibbles into a 32-bit word.
- Nibble index k lands in bits [4k+3:4k], so slot k is the nibble the selector returns for sel=k.
- Sits between a nibble-wide source (keypad/serial decoder, BCD digit stream) and any 32-bit consumer.
- Valid/ready handshakes on both sides; supports early termination of a partial word.

---
 rtl/nibble_pack8_if.sv | 37 +++
 rtl/nibble_pack8.sv | 102 ++++++++++
 tb/tb_nibble_pack8.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nibble_pack8_if.sv
// ---------------------------------------------------------------------------
// nibble_pack8_if : nibble-in / word-out handshake bundle for nibble_pack8
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface nibble_pack8_if #(
  parameter int NIB_W = 4,
  parameter int NIBS  = 8
);
  localparam int IDX_W  = $clog2(NIBS);
  localparam int CNT_W  = $clog2(NIBS + 1);
  localparam int DATA_W = NIB_W * NIBS;

  logic [NIB_W-1:0]  in_nib;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] dataout;
  logic [CNT_W-1:0]  out_count;
  logic              out_valid;
  logic              out_ready;
  logic [IDX_W-1:0]  wr_idx;

  // Driven by whoever feeds nibbles in and drains words out.
  modport master (
    output in_nib, in_valid, in_last, out_ready,
    input  in_ready, dataout, out_count, out_valid, wr_idx
  );

  modport slave (
    input  in_nib, in_valid, in_last, out_ready,
    output in_ready, dataout, out_count, out_valid, wr_idx
  );
endinterface

`default_nettype wire

// File: rtl/nibble_pack8.sv
// ---------------------------------------------------------------------------
// nibble_pack8 : packs a serial nibble stream into 32-bit words, slot k at [4k+3:4k]
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nibble_pack8 #(
  parameter int NIB_W = 4,
  parameter int NIBS  = 8
) (
  input  logic clk,
  input  logic rst,
  nibble_pack8_if.slave bus
);
  localparam int IDX_W  = $clog2(NIBS);
  localparam int CNT_W  = $clog2(NIBS + 1);
  localparam int DATA_W = NIB_W * NIBS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBS - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;
  logic              valid_q;
  logic [IDX_W-1:0]  wr_idx_q;

  logic              in_ready;
  logic              in_acc;
  logic [DATA_W-1:0] first_word;
  logic [CNT_W-1:0]  fill_count;

  // In HOLD a nibble may only enter on the same edge the held word leaves.
  assign in_ready   = (state_q == FILL) || bus.out_ready;
  assign in_acc     = bus.in_valid && in_ready;
  assign first_word = {{(DATA_W - NIB_W){1'b0}}, bus.in_nib};
  assign fill_count = {{(CNT_W - IDX_W){1'b0}}, wr_idx_q} + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      data_q   <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_acc) begin
            // Slot 0 of a new word wipes the rest so short words read zero-padded.
            if (wr_idx_q == '0) begin
              data_q <= first_word;
            end else begin
              data_q[wr_idx_q*NIB_W +: NIB_W] <= bus.in_nib;
            end
            if (bus.in_last || (wr_idx_q == LAST_IDX)) begin
              count_q  <= fill_count;
              valid_q  <= 1'b1;
              state_q  <= HOLD;
              wr_idx_q <= '0;
            end else begin
              wr_idx_q <= wr_idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              data_q <= first_word;
              if (bus.in_last) begin
                count_q <= CNT_W'(1);
              end else begin
                state_q  <= FILL;
                valid_q  <= 1'b0;
                wr_idx_q <= IDX_W'(1);
              end
            end else begin
              state_q <= FILL;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= FILL;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dataout   = data_q;
  assign bus.out_count = count_q;
  assign bus.out_valid = valid_q;
  assign bus.wr_idx    = wr_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_pack8.sv
// ---------------------------------------------------------------------------
// tb_nibble_pack8 : directed + random stimulus against a queue-based word model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nibble_pack8;
  logic clk;
  logic rst;

  nibble_pack8_if #(.NIB_W(4), .NIBS(8)) bus ();

  nibble_pack8 #(.NIB_W(4), .NIBS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp  = 0;
  int nfail = 0;

  // Model: nibbles of the word being collected, plus the word on offer.
  logic [3:0]  m_nibs[$];
  bit          m_ovalid;
  logic [31:0] m_word;
  int          m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_nib   = 4'($urandom);
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    m_nibs.delete();
    m_ovalid = 1'b0;
    m_word   = '0;
    m_count  = 0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_wr_idx", bus.wr_idx, 0);
    chk("rst_dataout", bus.dataout, 0);
    chk("rst_out_count", bus.out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic step(input bit v, input logic [3:0] n, input bit l, input bit ordy);
    bit exp_rdy;
    bit in_acc;
    bit out_acc;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_nib    = n;
    bus.in_last   = l;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !m_ovalid || ordy;
    chk("in_ready", bus.in_ready, exp_rdy);
    in_acc  = v && exp_rdy;
    out_acc = m_ovalid && ordy;
    @(posedge clk);
    #1;
    if (out_acc) m_ovalid = 1'b0;
    if (in_acc) begin
      m_nibs.push_back(n);
      if (l || m_nibs.size() == 8) begin
        m_word = '0;
        foreach (m_nibs[k]) m_word = m_word | (32'(m_nibs[k]) << (4 * k));
        m_count  = m_nibs.size();
        m_ovalid = 1'b1;
        m_nibs.delete();
      end
    end
    chk("out_valid", bus.out_valid, m_ovalid);
    chk("wr_idx", bus.wr_idx, m_nibs.size());
    if (m_ovalid) begin
      chk("dataout", bus.dataout, m_word);
      chk("out_count", bus.out_count, m_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_nib = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Full word 1..8
    for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    chk("full_word_const", bus.dataout, 32'h87654321);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Backpressure: A..F,0,1 held while nibble 9 waits
    for (int i = 0; i < 8; i++) step(1'b1, 4'(10 + i), 1'b0, 1'b0);
    repeat (5) step(1'b1, 4'h9, 1'b0, 1'b0);
    chk("bp_word_const", bus.dataout, 32'h10FEDCBA);
    step(1'b1, 4'h9, 1'b0, 1'b1);
    chk("bp_slot0", bus.dataout[3:0], 4'h9);
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom), 1'b0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Short word then full F's
    step(1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b1, 4'h5, 1'b0, 1'b1);
    step(1'b1, 4'h7, 1'b1, 1'b0);
    chk("short_const", bus.dataout, 32'h00000753);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'hF, 1'b0, 1'b1);
    chk("allf_const", bus.dataout, 32'hFFFFFFFF);

    // Back-to-back 0..F, in_ready checked every step
    for (int i = 0; i < 16; i++) step(1'b1, 4'(i), 1'b0, 1'b1);
    chk("b2b_const", bus.dataout, 32'hFEDCBA98);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Reset mid-word
    for (int i = 0; i < 5; i++) step(1'b1, 4'($urandom), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 4'h4, 1'b0, 1'b1);
    chk("fours_const", bus.dataout, 32'h44444444);

    // in_last on first nibble, then in_last nibble during HOLD; in_last on slot 7
    step(1'b1, 4'hC, 1'b1, 1'b1);
    chk("first_last_const", bus.dataout, 32'h0000000C);
    step(1'b1, 4'h6, 1'b1, 1'b1);
    chk("hold_last_const", bus.dataout, 32'h00000006);
    step(1'b0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 4'(i + 2), (i == 7), 1'b1);
    chk("slot7_last_cnt", bus.out_count, 8);
    step(1'b0, 4'h0, 1'b0, 1'b1);

    // Reset while holding a word
    step(1'b1, 4'h1, 1'b1, 1'b0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 5) == 0,
             $urandom_range(0, 2) != 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
